mem_arbiter: RTL and testbench

Two-port memory arbiter and transaction sequencer placed between the core's requesters (instruction fetch port, Executor data port) and the single shared memory bus. Grants the bus round-robin and runs one transaction at a time with a bus timeout. Converts the bus's one-cycle acknowledge into the level-held `memAccessOK`/data/exception response the Executor expects while it holds `memAccess` until writeback.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_bus_timeout_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter: exception codes,
// access widths, requester ownership and the registered bus command.
package mem_arbiter_pkg;

  localparam int EXCEPTION_LEN = 4;

  typedef logic [EXCEPTION_LEN-1:0] excep_t;
  typedef logic [1:0]               mem_width_t;

  localparam excep_t EXCEP_NONE         = 4'd0;
  localparam excep_t EXCEP_ACCESS_FAULT = 4'd5;

  localparam mem_width_t MEM_WIDTH_NONE = 2'd0;
  localparam mem_width_t MEM_WIDTH_BYTE = 2'd1;
  localparam mem_width_t MEM_WIDTH_HALF = 2'd2;
  localparam mem_width_t MEM_WIDTH_WORD = 2'd3;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_width_t  width;
    logic        is_read;
  } bus_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-bus signals of the arbiter. slave is the arbiter's view,
// master is the view of the surrounding system (fetch, Executor and memory).
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic         fetchAccess_In;
  logic [31:0]  fetchAddr_In;
  logic         fetchAccessOK_Out;
  logic [31:0]  fetchData_Out;
  excep_t       fetchException_Out;

  logic         dataAccess_In;
  logic [31:0]  dataAddr_In;
  logic [31:0]  dataWData_In;
  mem_width_t   dataWidth_In;
  logic         dataIsRead_In;
  logic         dataAccessOK_Out;
  logic [31:0]  dataRData_Out;
  excep_t       dataException_Out;

  logic         busReq_Out;
  logic [31:0]  busAddr_Out;
  logic [31:0]  busWData_Out;
  mem_width_t   busWidth_Out;
  logic         busIsRead_Out;
  logic         busAck_In;
  logic [31:0]  busRData_In;
  excep_t       busException_In;

  modport slave (
    input  fetchAccess_In, fetchAddr_In,
    output fetchAccessOK_Out, fetchData_Out, fetchException_Out,
    input  dataAccess_In, dataAddr_In, dataWData_In, dataWidth_In, dataIsRead_In,
    output dataAccessOK_Out, dataRData_Out, dataException_Out,
    output busReq_Out, busAddr_Out, busWData_Out, busWidth_Out, busIsRead_Out,
    input  busAck_In, busRData_In, busException_In
  );

  modport master (
    output fetchAccess_In, fetchAddr_In,
    input  fetchAccessOK_Out, fetchData_Out, fetchException_Out,
    output dataAccess_In, dataAddr_In, dataWData_In, dataWidth_In, dataIsRead_In,
    input  dataAccessOK_Out, dataRData_Out, dataException_Out,
    input  busReq_Out, busAddr_Out, busWData_Out, busWidth_Out, busIsRead_Out,
    output busAck_In, busRData_In, busException_In
  );

endinterface

// File: rtl/mem_arbiter_bus_timeout_counter.sv
// Counts BUSY cycles without an acknowledge. expired flags the cycle whose
// increment would reach TIMEOUT_CYCLES; TIMEOUT_CYCLES of 0 never expires.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_In,
  input  logic rstN_In,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_In or negedge rstN_In) begin
    if (!rstN_In) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (TIMEOUT_CYCLES != 0)) begin
      count_q <= count_q + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the fetch and data ports onto one memory bus,
// one transaction at a time, with bus timeout and a level-held response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic          clk_In,
  input logic          rstN_In,
  mem_arbiter_if.slave mif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  owner_e      owner_q, last_grant_q, grant_owner;
  logic        flush_q;
  logic        bus_req_q;
  bus_cmd_t    bus_cmd_q;
  logic [31:0] resp_data_q;
  excep_t      resp_exc_q;

  logic grant, grant_none, bus_done, timed_out, release_owner;
  logic owner_access, expired, count_en;

  assign owner_access = (owner_q == OWNER_DATA) ? mif.dataAccess_In : mif.fetchAccess_In;
  assign count_en     = (state_q == ST_BUSY) && !mif.busAck_In;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_In  (clk_In),
    .rstN_In (rstN_In),
    .clear   (grant),
    .enable  (count_en),
    .expired (expired)
  );

  always_ff @(posedge clk_In or negedge rstN_In) begin
    if (!rstN_In) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    grant_none    = 1'b0;
    grant_owner   = OWNER_FETCH;
    bus_done      = 1'b0;
    timed_out     = 1'b0;
    release_owner = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mif.fetchAccess_In || mif.dataAccess_In) begin
          grant       = 1'b1;
          grant_owner = (mif.dataAccess_In &&
                         (!mif.fetchAccess_In || last_grant_q == OWNER_FETCH))
                        ? OWNER_DATA : OWNER_FETCH;
          if (grant_owner == OWNER_DATA && mif.dataWidth_In == MEM_WIDTH_NONE) begin
            grant_none = 1'b1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (mif.busAck_In) begin
          bus_done = 1'b1;
        end else if (expired) begin
          bus_done  = 1'b1;
          timed_out = 1'b1;
        end
        if (bus_done) begin
          if (flush_q || !owner_access) begin
            state_d       = ST_IDLE;
            release_owner = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (!owner_access) begin
          state_d       = ST_IDLE;
          release_owner = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_In or negedge rstN_In) begin
    if (!rstN_In) begin
      owner_q      <= OWNER_FETCH;
      last_grant_q <= OWNER_FETCH;
      flush_q      <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_cmd_q    <= '{addr: '0, wdata: '0, width: MEM_WIDTH_NONE, is_read: 1'b1};
      resp_data_q  <= '0;
      resp_exc_q   <= EXCEP_NONE;
    end else begin
      if (grant) begin
        owner_q <= grant_owner;
        flush_q <= 1'b0;
        if (grant_none) begin
          resp_data_q <= '0;
          resp_exc_q  <= EXCEP_NONE;
        end else begin
          bus_req_q <= 1'b1;
          if (grant_owner == OWNER_DATA)
            bus_cmd_q <= '{addr: mif.dataAddr_In, wdata: mif.dataWData_In,
                           width: mif.dataWidth_In, is_read: mif.dataIsRead_In};
          else
            bus_cmd_q <= '{addr: mif.fetchAddr_In, wdata: '0,
                           width: MEM_WIDTH_WORD, is_read: 1'b1};
        end
      end
      // Remember an abandoned request so the late result is discarded.
      if (state_q == ST_BUSY && !owner_access) flush_q <= 1'b1;
      if (bus_done) begin
        bus_req_q   <= 1'b0;
        resp_data_q <= timed_out ? 32'd0 : mif.busRData_In;
        resp_exc_q  <= timed_out ? EXCEP_ACCESS_FAULT : mif.busException_In;
      end
      if (release_owner) last_grant_q <= owner_q;
    end
  end

  logic        fetch_ok, data_ok;
  logic [31:0] fetch_data, data_rdata;
  excep_t      fetch_exc, data_exc;

  always_comb begin
    fetch_ok   = 1'b0;
    fetch_data = '0;
    fetch_exc  = EXCEP_NONE;
    data_ok    = 1'b0;
    data_rdata = '0;
    data_exc   = EXCEP_NONE;
    if (state_q == ST_RESP) begin
      if (owner_q == OWNER_FETCH) begin
        fetch_ok   = mif.fetchAccess_In;
        fetch_data = resp_data_q;
        fetch_exc  = resp_exc_q;
      end else begin
        data_ok    = mif.dataAccess_In;
        data_rdata = resp_data_q;
        data_exc   = resp_exc_q;
      end
    end
  end

  assign mif.fetchAccessOK_Out  = fetch_ok;
  assign mif.fetchData_Out      = fetch_data;
  assign mif.fetchException_Out = fetch_exc;
  assign mif.dataAccessOK_Out   = data_ok;
  assign mif.dataRData_Out      = data_rdata;
  assign mif.dataException_Out  = data_exc;

  assign mif.busReq_Out    = bus_req_q;
  assign mif.busAddr_Out   = bus_cmd_q.addr;
  assign mif.busWData_Out  = bus_cmd_q.wdata;
  assign mif.busWidth_Out  = bus_cmd_q.width;
  assign mif.busIsRead_Out = bus_cmd_q.is_read;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of grant and response.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int T = 4;

  logic clk_In  = 1'b0;
  logic rstN_In = 1'b0;
  always #5 clk_In = ~clk_In;

  mem_arbiter_if mif();

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_In  (clk_In),
    .rstN_In (rstN_In),
    .mif     (mif)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  owner_e model_last = OWNER_FETCH;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.fetchAccess_In  = 1'b0;
    mif.fetchAddr_In    = '0;
    mif.dataAccess_In   = 1'b0;
    mif.dataAddr_In     = '0;
    mif.dataWData_In    = '0;
    mif.dataWidth_In    = MEM_WIDTH_NONE;
    mif.dataIsRead_In   = 1'b1;
    mif.busAck_In       = 1'b0;
    mif.busRData_In     = '0;
    mif.busException_In = EXCEP_NONE;
  endtask

  // Owner must see OK with the expected payload; the other port stays silent.
  task automatic check_resp(input owner_e win, input logic [31:0] exp_data, input excep_t exp_exc);
    if (win == OWNER_DATA) begin
      check("data_ok",      mif.dataAccessOK_Out,   1);
      check("data_rdata",   mif.dataRData_Out,      exp_data);
      check("data_exc",     mif.dataException_Out,  exp_exc);
      check("fetch_idle",   mif.fetchAccessOK_Out,  0);
      check("fetch_data0",  mif.fetchData_Out,      0);
    end else begin
      check("fetch_ok",     mif.fetchAccessOK_Out,  1);
      check("fetch_data",   mif.fetchData_Out,      exp_data);
      check("fetch_exc",    mif.fetchException_Out, exp_exc);
      check("data_idle",    mif.dataAccessOK_Out,   0);
      check("data_rdata0",  mif.dataRData_Out,      0);
    end
  endtask

  // One arbitration round: raise requests, act as the memory (ack after k
  // cycles of busReq, k >= T means never in time), check, then release.
  task automatic run_txn(input bit f, input bit d, input logic [31:0] faddr,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input mem_width_t width, input bit is_read, input int k,
                         input logic [31:0] rdata, input excep_t exc);
    owner_e      win;
    bit          none_path;
    logic [31:0] exp_data;
    excep_t      exp_exc;
    int          hi_cnt;
    win       = (d && (!f || model_last == OWNER_FETCH)) ? OWNER_DATA : OWNER_FETCH;
    none_path = (win == OWNER_DATA) && (width == MEM_WIDTH_NONE);
    if (none_path)   begin exp_data = 0;     exp_exc = EXCEP_NONE;         end
    else if (k >= T) begin exp_data = 0;     exp_exc = EXCEP_ACCESS_FAULT; end
    else             begin exp_data = rdata; exp_exc = exc;                end

    @(posedge clk_In); #1;
    mif.fetchAccess_In = f;
    mif.fetchAddr_In   = faddr;
    mif.dataAccess_In  = d;
    mif.dataAddr_In    = daddr;
    mif.dataWData_In   = wdata;
    mif.dataWidth_In   = width;
    mif.dataIsRead_In  = is_read;
    @(negedge clk_In);
    check("idle_busreq", mif.busReq_Out, 0);
    check("idle_ok", {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);

    if (none_path) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clk_In); #1;
        @(negedge clk_In);
        check("none_busreq", mif.busReq_Out, 0);
        check_resp(win, exp_data, exp_exc);
      end
    end else begin
      hi_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk_In); #1;
        mif.busAck_In       = (c == k + 1);
        mif.busRData_In     = (c == k + 1) ? rdata : (32'hA5A5_0000 | c);
        mif.busException_In = (c == k + 1) ? exc : EXCEP_NONE;
        @(negedge clk_In);
        if (c == 1) begin
          check("grant_busreq", mif.busReq_Out, 1);
          check("grant_addr",   mif.busAddr_Out, (win == OWNER_DATA) ? daddr : faddr);
          check("grant_width",  mif.busWidth_Out, (win == OWNER_DATA) ? width : MEM_WIDTH_WORD);
          check("grant_isread", mif.busIsRead_Out, (win == OWNER_DATA) ? is_read : 1'b1);
          if (win == OWNER_DATA) check("grant_wdata", mif.busWData_Out, wdata);
        end
        if (mif.busReq_Out) hi_cnt++;
        else check_resp(win, exp_data, exp_exc);
      end
      mif.busAck_In = 1'b0;
      check("busreq_len", hi_cnt, (k >= T) ? T : k + 1);
    end

    @(posedge clk_In); #1;
    mif.fetchAccess_In = 1'b0;
    mif.dataAccess_In  = 1'b0;
    @(negedge clk_In);
    check("release_ok", {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);
    model_last = win;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #12;
    check("rst_busreq", mif.busReq_Out, 0);
    check("rst_addr",   mif.busAddr_Out, 0);
    check("rst_wdata",  mif.busWData_Out, 0);
    check("rst_width",  mif.busWidth_Out, MEM_WIDTH_NONE);
    check("rst_isread", mif.busIsRead_Out, 1);
    check("rst_ok",     {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);
    check("rst_exc",    {mif.fetchException_Out, mif.dataException_Out}, {EXCEP_NONE, EXCEP_NONE});
    @(negedge clk_In);
    rstN_In = 1'b1;

    // Three simultaneous requests alternate data, fetch, data.
    for (int i = 0; i < 3; i++)
      run_txn(1, 1, 32'h1000 + 4 * i, 32'h2000 + 4 * i, 32'h0, MEM_WIDTH_WORD, 1, 0,
              32'hC0DE_0000 + i, EXCEP_NONE);
    // Load at 0x100 acked one cycle after busReq.
    run_txn(0, 1, 0, 32'h100, 0, MEM_WIDTH_WORD, 1, 1, 32'hDEAD_BEEF, EXCEP_NONE);
    // Store word.
    run_txn(0, 1, 0, 32'h200, 32'h1234_5678, MEM_WIDTH_WORD, 0, 0, 32'h0, EXCEP_NONE);
    // Timeout with an ack arriving two cycles into the response.
    run_txn(0, 1, 0, 32'h300, 0, MEM_WIDTH_WORD, 1, T + 2, 32'hFFFF_FFFF, 4'd3);
    // Ack on the same cycle the timeout would fire.
    run_txn(1, 0, 32'h340, 0, 0, MEM_WIDTH_WORD, 1, T - 1, 32'h5555_AAAA, 4'd2);
    // Zero-width data access answered without a bus cycle.
    run_txn(0, 1, 0, 32'h380, 0, MEM_WIDTH_NONE, 1, 0, 32'h0, EXCEP_NONE);

    // Fetch abandoned while BUSY; pending data request granted right after.
    @(posedge clk_In); #1;
    mif.fetchAccess_In = 1'b1;
    mif.fetchAddr_In   = 32'h4000;
    @(posedge clk_In); #1;
    @(negedge clk_In);
    check("flush_grant", mif.busAddr_Out, 32'h4000);
    @(posedge clk_In); #1;
    mif.fetchAccess_In = 1'b0;
    mif.dataAccess_In  = 1'b1;
    mif.dataAddr_In    = 32'h500;
    mif.dataWidth_In   = MEM_WIDTH_WORD;
    mif.dataIsRead_In  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        mif.busAck_In   = 1'b1;
        mif.busRData_In = 32'h1111_1111;
      end
      @(negedge clk_In);
      check("flush_busreq", mif.busReq_Out, 1);
      check("flush_no_ok", {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);
      @(posedge clk_In); #1;
    end
    mif.busAck_In = 1'b0;
    @(negedge clk_In);
    check("flush_idle_req", mif.busReq_Out, 0);
    check("flush_idle_ok", {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);
    @(posedge clk_In); #1;
    mif.busAck_In   = 1'b1;
    mif.busRData_In = 32'h2222_2222;
    @(negedge clk_In);
    check("flush_next_req",  mif.busReq_Out, 1);
    check("flush_next_addr", mif.busAddr_Out, 32'h500);
    @(posedge clk_In); #1;
    mif.busAck_In = 1'b0;
    @(negedge clk_In);
    check_resp(OWNER_DATA, 32'h2222_2222, EXCEP_NONE);
    @(posedge clk_In); #1;
    mif.dataAccess_In = 1'b0;
    @(negedge clk_In);
    check("flush_release", mif.dataAccessOK_Out, 0);
    model_last = OWNER_DATA;

    // Randomized rounds.
    for (int i = 0; i < 40; i++) begin
      bit f, d;
      f = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!f && !d) d = 1'b1;
      run_txn(f, d, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom,
              4'($urandom_range(0, 15)));
    end

    // Asynchronous reset in the middle of a bus transaction.
    @(posedge clk_In); #1;
    mif.dataAccess_In = 1'b1;
    mif.dataAddr_In   = 32'h700;
    mif.dataWidth_In  = MEM_WIDTH_WORD;
    @(posedge clk_In); #1;
    @(negedge clk_In);
    check("arst_busy", mif.busReq_Out, 1);
    #2 rstN_In = 1'b0;
    #1;
    check("arst_busreq", mif.busReq_Out, 0);
    check("arst_addr",   mif.busAddr_Out, 0);
    check("arst_width",  mif.busWidth_Out, MEM_WIDTH_NONE);
    check("arst_isread", mif.busIsRead_Out, 1);
    check("arst_ok", {mif.fetchAccessOK_Out, mif.dataAccessOK_Out}, 0);
    idle_inputs();
    @(negedge clk_In);
    rstN_In    = 1'b1;
    model_last = OWNER_FETCH;
    // After reset the tie goes to data again.
    run_txn(1, 1, 32'h800, 32'h900, 0, MEM_WIDTH_WORD, 1, 0, 32'h600D_F00D, EXCEP_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
